// File: rtl/match_stage_ctrl.sv
// Line sequencer for the match stage: dictionary flush, LINE_WORDS-beat accept, tag pipe of PIPE_DEPTH.
// Latency PIPE_DEPTH cycles accept-to-output; the whole tag pipe and intake freeze while output is stalled.
module match_stage_ctrl #(
  parameter int WIDTH      = 64,
  parameter int LINE_WORDS = 8,
  parameter int PIPE_DEPTH = 3
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_start,
  input  logic                          i_in_valid,
  input  logic [WIDTH-1:0]              i_in_data,
  output logic                          o_in_ready,
  output logic [WIDTH-1:0]              o_word,
  output logic                          o_dict_clear,
  output logic                          o_dict_wr_en,
  input  logic                          i_out_ready,
  output logic                          o_out_valid,
  output logic                          o_last,
  output logic [$clog2(LINE_WORDS):0]   o_beat_cnt,
  output logic                          o_busy,
  output logic                          o_done
);

  localparam int CW = $clog2(LINE_WORDS) + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [PIPE_DEPTH-1:0] vld_q, vld_d;
  logic [PIPE_DEPTH-1:0] last_q, last_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  advance;
  logic                  in_ready;
  logic                  accept;

  always_comb begin
    advance  = !vld_q[PIPE_DEPTH-1] || i_out_ready;
    in_ready = (state_q == S_STREAM) && advance;
    accept   = i_in_valid && in_ready;

    state_d = state_q;
    vld_d   = vld_q;
    last_d  = last_q;
    cnt_d   = cnt_q;

    // Tag pipe shifts as a unit; a bubble enters stage 0 when nothing is accepted.
    if (advance) begin
      for (int i = PIPE_DEPTH - 1; i > 0; i--) begin
        vld_d[i]  = vld_q[i-1];
        last_d[i] = last_q[i-1];
      end
      vld_d[0]  = accept;
      last_d[0] = accept && (cnt_q == LAST_IDX);
    end

    case (state_q)
      S_IDLE: begin
        if (i_start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        cnt_d   = '0;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (accept) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_IDX) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (vld_q[PIPE_DEPTH-1] && last_q[PIPE_DEPTH-1] && i_out_ready) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      vld_q   <= '0;
      last_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_in_ready   = in_ready;
  assign o_word       = i_in_data;
  assign o_dict_clear = (state_q == S_CLEAR);
  assign o_dict_wr_en = accept;
  assign o_out_valid  = vld_q[PIPE_DEPTH-1];
  assign o_last       = last_q[PIPE_DEPTH-1];
  assign o_beat_cnt   = cnt_q;
  assign o_busy       = (state_q != S_IDLE);
  assign o_done       = (state_q == S_DONE);

endmodule

// File: tb/tb_match_stage_ctrl.sv
// Directed bench for match_stage_ctrl at default parameters.
module tb_match_stage_ctrl;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_start;
  logic        i_in_valid;
  logic [63:0] i_in_data;
  logic        o_in_ready;
  logic [63:0] o_word;
  logic        o_dict_clear;
  logic        o_dict_wr_en;
  logic        i_out_ready;
  logic        o_out_valid;
  logic        o_last;
  logic [3:0]  o_beat_cnt;
  logic        o_busy;
  logic        o_done;

  int passed = 0;
  int total  = 0;

  always #5 i_clk = ~i_clk;

  match_stage_ctrl dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_start      (i_start),
    .i_in_valid   (i_in_valid),
    .i_in_data    (i_in_data),
    .o_in_ready   (o_in_ready),
    .o_word       (o_word),
    .o_dict_clear (o_dict_clear),
    .o_dict_wr_en (o_dict_wr_en),
    .i_out_ready  (i_out_ready),
    .o_out_valid  (o_out_valid),
    .o_last       (o_last),
    .o_beat_cnt   (o_beat_cnt),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Full-rate line starting at k=0; restart_k is an extra i_start pulse (negative for none).
  task automatic run_full(input int prev_cnt, input int restart_k);
    int exp_cnt;
    for (int k = 0; k < 16; k++) begin
      i_start     = (k == 0) || (k == restart_k);
      i_in_valid  = 1'b1;
      i_out_ready = 1'b1;
      i_in_data   = 64'hA5A5_0000_0000_0000 + 64'(k);
      #1;
      exp_cnt = (k < 2) ? prev_cnt : ((k - 2 > 8) ? 8 : k - 2);
      chk($sformatf("full_clear_k%0d", k),  o_dict_clear, (k == 1));
      chk($sformatf("full_wr_k%0d", k),     o_dict_wr_en, (k >= 2 && k <= 9));
      chk($sformatf("full_inrdy_k%0d", k),  o_in_ready,   (k >= 2 && k <= 9));
      chk($sformatf("full_ovld_k%0d", k),   o_out_valid,  (k >= 5 && k <= 12));
      chk($sformatf("full_last_k%0d", k),   o_last,       (k == 12));
      chk($sformatf("full_done_k%0d", k),   o_done,       (k == 13));
      chk($sformatf("full_busy_k%0d", k),   o_busy,       (k >= 1 && k <= 13));
      chk($sformatf("full_cnt_k%0d", k),    64'(o_beat_cnt), 64'(exp_cnt));
      chk($sformatf("full_word_k%0d", k),   o_word,       i_in_data);
      step();
    end
    i_start = 1'b0;
  endtask

  initial begin
    int n_out, n_last, last_at, n_wr, last_cnt;
    bit seen_done;

    i_reset = 1'b1; i_start = 1'b0; i_in_valid = 1'b0; i_in_data = '0; i_out_ready = 1'b0;

    // Reset held two cycles with random inputs.
    for (int k = 0; k < 2; k++) begin
      i_start     = 1'($urandom);
      i_in_valid  = 1'($urandom);
      i_out_ready = 1'($urandom);
      i_in_data   = {$urandom, $urandom};
      step();
    end
    i_reset = 1'b0; i_start = 1'b0; i_in_valid = 1'b0; i_out_ready = 1'b0;
    #1;
    chk("rst_inrdy", o_in_ready,   1'b0);
    chk("rst_clear", o_dict_clear, 1'b0);
    chk("rst_wr",    o_dict_wr_en, 1'b0);
    chk("rst_ovld",  o_out_valid,  1'b0);
    chk("rst_last",  o_last,       1'b0);
    chk("rst_busy",  o_busy,       1'b0);
    chk("rst_done",  o_done,       1'b0);
    chk("rst_cnt",   64'(o_beat_cnt), 64'd0);
    step();

    run_full(0, -1);

    // Backpressure: output stalled cycles 6..9 with the pipe full.
    n_out = 0; n_last = 0; last_at = 0; n_wr = 0; seen_done = 1'b0;
    for (int k = 0; k < 60 && !seen_done; k++) begin
      i_start     = (k == 0);
      i_in_valid  = 1'b1;
      i_out_ready = !(k >= 6 && k <= 9);
      i_in_data   = 64'(k);
      #1;
      if (k >= 6 && k <= 9) begin
        chk($sformatf("bp_inrdy_k%0d", k), o_in_ready,   1'b0);
        chk($sformatf("bp_wr_k%0d", k),    o_dict_wr_en, 1'b0);
        chk($sformatf("bp_cnt_k%0d", k),   64'(o_beat_cnt), 64'd4);
        chk($sformatf("bp_ovld_k%0d", k),  o_out_valid,  1'b1);
      end
      if (o_dict_wr_en) n_wr++;
      if (o_out_valid && i_out_ready) begin
        n_out++;
        if (o_last) begin
          n_last++;
          last_at = n_out;
        end
      end
      if (o_done) seen_done = 1'b1;
      step();
    end
    chk("bp_done_seen", seen_done, 1'b1);
    chk("bp_accepts",   64'(n_wr),    64'd8);
    chk("bp_outs",      64'(n_out),   64'd8);
    chk("bp_nlast",     64'(n_last),  64'd1);
    chk("bp_last_pos",  64'(last_at), 64'd8);
    i_in_valid = 1'b0;
    #1;
    chk("bp_idle", o_busy, 1'b0);

    // Input bubbles: valid on even cycles only.
    n_wr = 0; n_last = 0; last_cnt = 0; seen_done = 1'b0;
    for (int k = 0; k < 80 && !seen_done; k++) begin
      i_start     = (k == 0);
      i_in_valid  = (k % 2 == 0);
      i_out_ready = 1'b1;
      #1;
      if (o_dict_wr_en) n_wr++;
      if (o_out_valid && o_last) n_last++;
      if (o_done) begin
        seen_done = 1'b1;
        last_cnt  = int'(o_beat_cnt);
      end
      step();
    end
    chk("bub_done_seen", seen_done, 1'b1);
    chk("bub_wr_pulses", 64'(n_wr),     64'd8);
    chk("bub_nlast",     64'(n_last),   64'd1);
    chk("bub_cnt",       64'(last_cnt), 64'd8);
    i_in_valid = 1'b0;
    step();

    // i_start re-pulsed when the count reads 3 in STREAM.
    run_full(8, 5);

    // Reset after five accepts.
    for (int k = 0; k < 7; k++) begin
      i_start     = (k == 0);
      i_in_valid  = 1'b1;
      i_out_ready = 1'b1;
      step();
    end
    i_start = 1'b0;
    #1;
    chk("mid_cnt_before", 64'(o_beat_cnt), 64'd5);
    i_reset = 1'b1;
    step();
    i_reset = 1'b0; i_in_valid = 1'b0;
    #1;
    chk("mid_ovld",  o_out_valid, 1'b0);
    chk("mid_cnt",   64'(o_beat_cnt), 64'd0);
    chk("mid_busy",  o_busy,      1'b0);
    chk("mid_inrdy", o_in_ready,  1'b0);
    step();

    run_full(0, -1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
